store_buffer: RTL

- Sits directly downstream of the store byte-alignment stage.
- Accepts stores that are already lane-aligned (double-word address, 64-bit data, 8-bit byte mask) and queues them in order.
- Drains them one per grant to the data-memory write port.
- Merges a new store into the youngest entry when both hit the same double-word.
- Flags loads that overlap pending bytes, so the pipeline stalls the load until the store drains.

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/store_buffer_byte_merge.sv | 22 ++
 rtl/store_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the store buffer.
// Imported by the buffer top and its byte-merge helper.
package store_buffer_pkg;

    localparam int STB_DEPTH = 4;

    typedef struct packed {
        logic [60:0] dw_addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } stb_entry_t;

endpackage

// File: rtl/store_buffer_byte_merge.sv
// Byte-granular merge of a new store into an existing entry.
// Purely combinational; new bytes win where their enable is set.
module stb_byte_merge (
    input  logic [63:0] old_data_i,
    input  logic [7:0]  old_mask_i,
    input  logic [63:0] new_data_i,
    input  logic [7:0]  new_mask_i,
    output logic [63:0] data_o,
    output logic [7:0]  mask_o
);

    always_comb begin
        data_o = old_data_i;
        for (int b = 0; b < 8; b++) begin
            if (new_mask_i[b]) begin
                data_o[b*8 +: 8] = new_data_i[b*8 +: 8];
            end
        end
        mask_o = old_mask_i | new_mask_i;
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the store align stage and the data-memory
// write port, with youngest-entry merging and a load-overlap hazard probe.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [63:0]                st_addr_i,
    input  logic [63:0]                st_data_i,
    input  logic [7:0]                 st_mask_i,
    output logic                       mem_req_o,
    output logic [63:0]                mem_addr_o,
    output logic [63:0]                mem_data_o,
    output logic [7:0]                 mem_mask_o,
    input  logic                       mem_gnt_i,
    input  logic                       ld_valid_i,
    input  logic [63:0]                ld_addr_i,
    input  logic [7:0]                 ld_mask_i,
    output logic                       ld_hazard_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stb_entry_t          ent_q [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PW-1:0]       head_q;
    logic [PW-1:0]       tail_q;
    logic [CW-1:0]       count_q;

    logic [PW-1:0]       tail_m1;
    logic                merge_hit;
    logic                accept;
    logic                do_enq;
    logic                do_merge;
    logic                deq;
    logic                hz;
    logic [63:0]         mrg_data;
    logic [7:0]          mrg_mask;
    logic                unused_lsbs;

    assign unused_lsbs = ^{st_addr_i[2:0], ld_addr_i[2:0]};

    assign tail_m1 = tail_q - 1'b1;

    // Head is never a merge target: it may be on the memory port right now.
    assign merge_hit = st_valid_i
                     & (count_q >= CW'(2))
                     & (ent_q[tail_m1].dw_addr == st_addr_i[63:3]);

    assign st_ready_o = (count_q < CW'(DEPTH)) | merge_hit;
    assign accept     = st_valid_i & st_ready_o;
    assign do_enq     = accept & ~merge_hit & (|st_mask_i);
    assign do_merge   = accept & merge_hit & (|st_mask_i);

    assign mem_req_o  = (count_q != '0);
    assign deq        = mem_req_o & mem_gnt_i;
    assign mem_addr_o = {ent_q[head_q].dw_addr, 3'b000};
    assign mem_data_o = ent_q[head_q].data;
    assign mem_mask_o = ent_q[head_q].mask;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    stb_byte_merge u_merge (
        .old_data_i (ent_q[tail_m1].data),
        .old_mask_i (ent_q[tail_m1].mask),
        .new_data_i (st_data_i),
        .new_mask_i (st_mask_i),
        .data_o     (mrg_data),
        .mask_o     (mrg_mask)
    );

    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]
                && (ent_q[i].dw_addr == ld_addr_i[63:3])
                && (|(ent_q[i].mask & ld_mask_i))) begin
                hz = 1'b1;
            end
        end
        ld_hazard_o = ld_valid_i & hz;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (deq) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            if (do_enq) begin
                ent_q[tail_q].dw_addr <= st_addr_i[63:3];
                ent_q[tail_q].data    <= st_data_i;
                ent_q[tail_q].mask    <= st_mask_i;
                vld_q[tail_q]         <= 1'b1;
                tail_q                <= tail_q + 1'b1;
            end
            if (do_merge) begin
                ent_q[tail_m1].data <= mrg_data;
                ent_q[tail_m1].mask <= mrg_mask;
            end
            count_q <= count_q + CW'(do_enq) - CW'(deq);
        end
    end

endmodule
